// File: rtl/state_dump_unit.sv
// Snapshot dumper: on each committed instruction it stalls the CPU and streams
// the PC, the register file and the low data-memory words as tagged records.
module state_dump_unit #(
    parameter int DATA_W        = 32,
    parameter int NUM_REGS      = 32,
    parameter int NUM_MEM_WORDS = 8,
    parameter int MAX_CYCLES    = 60,
    parameter int HALT_LIMIT    = 4,
    localparam int RA_W         = $clog2(NUM_REGS),
    localparam int MA_W         = $clog2(NUM_MEM_WORDS) + 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              snap_i,
    input  logic [DATA_W-1:0] pc_i,
    output logic [RA_W-1:0]   reg_addr_o,
    input  logic [DATA_W-1:0] reg_data_i,
    output logic [MA_W-1:0]   mem_addr_o,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              stall_o,
    output logic              rec_valid_o,
    input  logic              rec_ready_i,
    output logic [1:0]        rec_tag_o,
    output logic [15:0]       rec_index_o,
    output logic [DATA_W-1:0] rec_data_o,
    output logic [15:0]       cycle_cnt_o,
    output logic              halt_o,
    output logic              done_o
);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        EMIT_PC,
        EMIT_REG,
        EMIT_MEM,
        EMIT_END,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        TAG_PC  = 2'd0,
        TAG_REG = 2'd1,
        TAG_MEM = 2'd2,
        TAG_END = 2'd3
    } tag_t;

    localparam logic [15:0] LAST_REG = 16'(NUM_REGS - 1);
    localparam logic [15:0] LAST_MEM = 16'(NUM_MEM_WORDS - 1);
    localparam logic [15:0] MAX_CYC  = 16'(MAX_CYCLES);
    localparam logic [15:0] EQ_LIMIT = 16'((HALT_LIMIT > 1) ? HALT_LIMIT - 1 : 0);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   pc_q;
    logic [15:0]         cycle_cnt_q;
    logic [15:0]         eq_cnt_q;
    logic [15:0]         eq_next;
    logic                halt_q;
    logic [15:0]         idx_q;
    logic                snap_take;
    logic                cycle_limit;

    assign snap_take   = (state_q == ARMED) && snap_i;
    assign cycle_limit = (MAX_CYCLES != 0) && (cycle_cnt_q == MAX_CYC);
    assign cycle_cnt_o = cycle_cnt_q;
    assign halt_o      = halt_q;

    // The very first snapshot has no predecessor, so it can never count as a repeat.
    always_comb begin
        eq_next = '0;
        if ((cycle_cnt_q != 16'd0) && (pc_i == pc_q)) begin
            eq_next = (eq_cnt_q >= EQ_LIMIT) ? eq_cnt_q : eq_cnt_q + 16'd1;
        end
    end

    // NOTE: every output defaults first, so no path through the case can infer a latch.
    always_comb begin
        state_d     = state_q;
        stall_o     = 1'b0;
        rec_valid_o = 1'b0;
        rec_tag_o   = TAG_PC;
        rec_index_o = '0;
        rec_data_o  = '0;
        reg_addr_o  = '0;
        mem_addr_o  = '0;
        done_o      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = ARMED;
            end
            ARMED: begin
                if (snap_i) state_d = EMIT_PC;
            end
            EMIT_PC: begin
                stall_o     = 1'b1;
                rec_valid_o = 1'b1;
                rec_tag_o   = TAG_PC;
                rec_index_o = cycle_cnt_q;
                rec_data_o  = pc_q;
                if (rec_ready_i) state_d = EMIT_REG;
            end
            EMIT_REG: begin
                stall_o     = 1'b1;
                rec_valid_o = 1'b1;
                reg_addr_o  = idx_q[RA_W-1:0];
                rec_tag_o   = TAG_REG;
                rec_index_o = idx_q;
                rec_data_o  = reg_data_i;
                if (rec_ready_i && (idx_q == LAST_REG)) state_d = EMIT_MEM;
            end
            EMIT_MEM: begin
                stall_o     = 1'b1;
                rec_valid_o = 1'b1;
                mem_addr_o  = {idx_q[MA_W-3:0], 2'b00};
                rec_tag_o   = TAG_MEM;
                rec_index_o = {idx_q[13:0], 2'b00};
                rec_data_o  = mem_data_i;
                if (rec_ready_i && (idx_q == LAST_MEM)) begin
                    state_d = (cycle_limit || halt_q) ? EMIT_END : ARMED;
                end
            end
            EMIT_END: begin
                stall_o     = 1'b1;
                rec_valid_o = 1'b1;
                rec_tag_o   = TAG_END;
                rec_index_o = cycle_cnt_q;
                rec_data_o  = pc_q;
                if (rec_ready_i) state_d = DONE;
            end
            DONE: begin
                done_o = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q        <= '0;
            cycle_cnt_q <= '0;
            eq_cnt_q    <= '0;
            halt_q      <= 1'b0;
            idx_q       <= '0;
        end else begin
            if (snap_take) begin
                pc_q     <= pc_i;
                eq_cnt_q <= eq_next;
                if (cycle_cnt_q != 16'hFFFF) cycle_cnt_q <= cycle_cnt_q + 16'd1;
                if (eq_next >= EQ_LIMIT) halt_q <= 1'b1;
            end
            // idx is cleared on every section exit, so each section starts at 0.
            case (state_q)
                EMIT_PC: begin
                    if (rec_ready_i) idx_q <= '0;
                end
                EMIT_REG: begin
                    if (rec_ready_i) idx_q <= (idx_q == LAST_REG) ? 16'd0 : idx_q + 16'd1;
                end
                EMIT_MEM: begin
                    if (rec_ready_i) idx_q <= (idx_q == LAST_MEM) ? 16'd0 : idx_q + 16'd1;
                end
                default: idx_q <= idx_q;
            endcase
        end
    end

endmodule

// File: tb/tb_state_dump_unit.sv
// Scoreboard bench for state_dump_unit: stimulus queues expected records, a
// negedge monitor pops and compares each transferred record.
module tb_state_dump_unit;

    typedef logic [49:0] rec_t;

    logic        clk;
    logic        rst_a, rst_b;
    logic        start, snap, ready;
    logic [31:0] pc_in;
    bit          use_b;

    logic [4:0]  a_reg_addr, b_reg_addr, a_mem_addr, b_mem_addr;
    logic [31:0] a_reg_data, b_reg_data, a_mem_data, b_mem_data;
    logic        a_stall, b_stall, a_valid, b_valid, a_halt, b_halt, a_done, b_done;
    logic [1:0]  a_tag, b_tag;
    logic [15:0] a_index, b_index, a_cycle, b_cycle;
    logic [31:0] a_data, b_data;

    logic        m_stall, m_valid, m_halt, m_done;
    logic [1:0]  m_tag;
    logic [15:0] m_index, m_cycle;
    logic [31:0] m_data;

    rec_t        exp_q[$];
    int          n_vec  = 0;
    int          n_miss = 0;
    bit          held   = 1'b0;
    rec_t        held_rec;

    function automatic logic [31:0] reg_val(input logic [4:0] a);
        return 32'hA5A5_0000 + 32'(a) * 32'h0101;
    endfunction

    function automatic logic [31:0] mem_val(input logic [4:0] a);
        return 32'hC0DE_0000 | {27'd0, a};
    endfunction

    assign a_reg_data = reg_val(a_reg_addr);
    assign b_reg_data = reg_val(b_reg_addr);
    assign a_mem_data = mem_val(a_mem_addr);
    assign b_mem_data = mem_val(b_mem_addr);

    assign m_stall = use_b ? b_stall : a_stall;
    assign m_valid = use_b ? b_valid : a_valid;
    assign m_halt  = use_b ? b_halt  : a_halt;
    assign m_done  = use_b ? b_done  : a_done;
    assign m_tag   = use_b ? b_tag   : a_tag;
    assign m_index = use_b ? b_index : a_index;
    assign m_cycle = use_b ? b_cycle : a_cycle;
    assign m_data  = use_b ? b_data  : a_data;

    state_dump_unit u_dut_a (
        .clk_i(clk), .rst_i(rst_a), .start_i(start), .snap_i(snap), .pc_i(pc_in),
        .reg_addr_o(a_reg_addr), .reg_data_i(a_reg_data),
        .mem_addr_o(a_mem_addr), .mem_data_i(a_mem_data),
        .stall_o(a_stall), .rec_valid_o(a_valid), .rec_ready_i(ready),
        .rec_tag_o(a_tag), .rec_index_o(a_index), .rec_data_o(a_data),
        .cycle_cnt_o(a_cycle), .halt_o(a_halt), .done_o(a_done)
    );

    state_dump_unit #(.MAX_CYCLES(3)) u_dut_b (
        .clk_i(clk), .rst_i(rst_b), .start_i(start), .snap_i(snap), .pc_i(pc_in),
        .reg_addr_o(b_reg_addr), .reg_data_i(b_reg_data),
        .mem_addr_o(b_mem_addr), .mem_data_i(b_mem_data),
        .stall_o(b_stall), .rec_valid_o(b_valid), .rec_ready_i(ready),
        .rec_tag_o(b_tag), .rec_index_o(b_index), .rec_data_o(b_data),
        .cycle_cnt_o(b_cycle), .halt_o(b_halt), .done_o(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a record transfers on the next rising edge when valid and ready are high here.
    always @(negedge clk) begin
        if (m_valid) begin
            if (held) check("hold_stable", 64'({m_tag, m_index, m_data}), 64'(held_rec));
            if (ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_record: got %h with nothing expected",
                             {m_tag, m_index, m_data});
                end else begin
                    check("record", 64'({m_tag, m_index, m_data}), 64'(exp_q.pop_front()));
                end
                held = 1'b0;
            end else begin
                held     = 1'b1;
                held_rec = {m_tag, m_index, m_data};
            end
        end else begin
            held = 1'b0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_snap(input logic [31:0] pc);
        snap  = 1'b1;
        pc_in = pc;
        tick();
        snap  = 1'b0;
        pc_in = '0;
    endtask

    task automatic do_snap(input logic [31:0] pc, input logic [15:0] cyc, input bit end_exp,
                           input bit toggle, input bit inject, input int exp_stall);
        int n_stall;
        exp_q.push_back({2'd0, cyc, pc});
        for (int i = 0; i < 32; i++) exp_q.push_back({2'd1, 16'(i), reg_val(5'(i))});
        for (int i = 0; i < 8; i++) exp_q.push_back({2'd2, 16'(i * 4), mem_val(5'(i * 4))});
        if (end_exp) exp_q.push_back({2'd3, cyc, pc});
        pulse_snap(pc);
        n_stall = 0;
        while (m_stall && n_stall < 1000) begin
            n_stall++;
            if (toggle) ready = ~ready;
            snap = inject && (n_stall == 5);
            if (snap) pc_in = 32'h0000_0BAD;
            tick();
        end
        snap  = 1'b0;
        pc_in = '0;
        ready = 1'b1;
        if (n_stall >= 1000) begin
            n_vec++;
            n_miss++;
            $display("FAIL stall_timeout: stall still high after %0d cycles", n_stall);
        end
        if (exp_stall != 0) check("stall_cycles", 64'(n_stall), 64'(exp_stall));
        check("cycle_cnt", 64'(m_cycle), 64'(cyc));
        check("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int guard;
        rst_a = 1'b0; rst_b = 1'b0; start = 1'b0; snap = 1'b0;
        pc_in = '0;   ready = 1'b1; use_b = 1'b0;
        tick();
        tick();
        check("rst_valid", 64'(a_valid), 64'd0);
        check("rst_stall", 64'(a_stall), 64'd0);
        check("rst_cycle", 64'(a_cycle), 64'd0);
        check("rst_flags", 64'({a_halt, a_done}), 64'd0);
        check("rst_addr",  64'({a_reg_addr, a_mem_addr}), 64'd0);
        rst_a = 1'b1;
        tick();

        // snap while IDLE is ignored
        pulse_snap(32'h44);
        tick();
        check("idle_snap_cnt",   64'(a_cycle), 64'd0);
        check("idle_snap_stall", 64'(a_stall), 64'd0);

        // first snapshot: 41 records, with a snap pulse mid-dump that must be ignored
        pulse_start();
        do_snap(32'h4, 16'd1, 1'b0, 1'b0, 1'b1, 41);
        check("armed_no_done", 64'(a_done), 64'd0);

        // backpressure: ready toggles every cycle
        do_snap(32'h8, 16'd2, 1'b0, 1'b1, 1'b0, 0);

        // halt: PC 0x10 four times; the fourth snapshot ends with END
        do_snap(32'h10, 16'd3, 1'b0, 1'b0, 1'b0, 41);
        do_snap(32'h10, 16'd4, 1'b0, 1'b0, 1'b0, 41);
        do_snap(32'h10, 16'd5, 1'b0, 1'b0, 1'b0, 41);
        check("halt_before", 64'(a_halt), 64'd0);
        do_snap(32'h10, 16'd6, 1'b1, 1'b0, 1'b0, 42);
        check("halt_after", 64'(a_halt), 64'd1);
        check("done_halt",  64'(a_done), 64'd1);
        pulse_start();
        pulse_snap(32'h99);
        tick();
        check("done_snap_cnt",   64'(a_cycle), 64'd6);
        check("done_snap_stall", 64'(a_stall), 64'd0);
        check("done_sticky",     64'(a_done), 64'd1);

        // reset in the middle of the register section
        rst_a = 1'b0;
        tick();
        rst_a = 1'b1;
        pulse_start();
        exp_q.push_back({2'd0, 16'd1, 32'h20});
        for (int i = 0; i < 10; i++) exp_q.push_back({2'd1, 16'(i), reg_val(5'(i))});
        pulse_snap(32'h20);
        guard = 0;
        while (!(a_valid && a_tag == 2'd1 && a_index == 16'd10) && guard < 200) begin
            guard++;
            tick();
        end
        check("reached_reg10", 64'(guard < 200), 64'd1);
        rst_a = 1'b0;
        #1;
        check("abort_valid", 64'(a_valid), 64'd0);
        check("abort_stall", 64'(a_stall), 64'd0);
        tick();
        rst_a = 1'b1;
        check("abort_cycle",   64'(a_cycle), 64'd0);
        check("abort_drained", 64'(exp_q.size()), 64'd0);
        pulse_snap(32'h30);
        tick();
        check("post_rst_idle_cnt",   64'(a_cycle), 64'd0);
        check("post_rst_idle_stall", 64'(a_stall), 64'd0);

        // cycle limit of 3 on the second instance
        rst_a = 1'b0;
        use_b = 1'b1;
        rst_b = 1'b1;
        tick();
        pulse_start();
        do_snap(32'h0, 16'd1, 1'b0, 1'b0, 1'b0, 41);
        do_snap(32'h4, 16'd2, 1'b0, 1'b0, 1'b0, 41);
        do_snap(32'h8, 16'd3, 1'b1, 1'b0, 1'b0, 42);
        check("limit_done", 64'(b_done), 64'd1);
        check("limit_halt", 64'(b_halt), 64'd0);
        pulse_snap(32'hC);
        tick();
        check("limit_snap_cnt",   64'(b_cycle), 64'd3);
        check("limit_snap_stall", 64'(b_stall), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/state_dump_unit.md
STATE_DUMP_UNIT -- requirements
Module: state_dump_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the width of the PC, register and memory words.
REQ-002 SHALL have parameter NUM_REGS, default 32, meaning the number of register-file entries dumped per snapshot (index width RA_W = clog2(NUM_REGS)).
REQ-003 SHALL have parameter NUM_MEM_WORDS, default 8, meaning the number of 32-bit data-memory words dumped, from byte address 0x00 upward (MA_W = clog2(NUM_MEM_WORDS)+2).
REQ-004 SHALL have parameter MAX_CYCLES, default 60, meaning the number of snapshots after which the dump terminates.
REQ-005 SHALL have parameter HALT_LIMIT, default 4, meaning the number of consecutive identical snapshot PCs that flags a halt.
REQ-006 SHALL have the following ports (one clock; reset asynchronous, active-low):
  clk_i  in  1  clock, all state on rising edge
  rst_i  in  1  asynchronous active-low reset
  start_i  in  1  arm request, sampled only in IDLE
  snap_i  in  1  one-cycle pulse: CPU committed an instruction this edge
  pc_i  in  DATA_W  CPU PC at the snap edge
  reg_addr_o  out  RA_W  register-file read address
  reg_data_i  in  DATA_W  combinational read data for reg_addr_o
  mem_addr_o  out  MA_W  data-memory byte address, word aligned
  mem_data_i  in  DATA_W  combinational read word for mem_addr_o
  stall_o  out  1  freeze CPU while a snapshot is emitted
  rec_valid_o  out  1  record valid
  rec_ready_i  in  1  sink accepts record
  rec_tag_o  out  2  0=PC, 1=REG, 2=MEM, 3=END
  rec_index_o  out  16  snapshot number / register index / byte address
  rec_data_o  out  DATA_W  record payload
  cycle_cnt_o  out  16  snapshots taken
  halt_o  out  1  halt detected (sticky)
  done_o  out  1  dump finished (sticky)

Function
REQ-007 SHALL implement FSM states IDLE, ARMED, EMIT_PC, EMIT_REG, EMIT_MEM, EMIT_END, DONE.
REQ-008 IDLE: start_i=1 -> ARMED next edge; otherwise stay; snap_i ignored.
REQ-009 ARMED: snap_i=1 -> capture pc_i into pc_q, cycle_cnt+1, -> EMIT_PC.
REQ-010 stall_o SHALL be 1 exactly in EMIT_PC/EMIT_REG/EMIT_MEM/EMIT_END, combinational from state.
REQ-011 A record SHALL transfer on an edge with rec_valid_o=1 and rec_ready_i=1; rec_valid_o SHALL be 1 in every EMIT_* state and 0 elsewhere.
REQ-012 While rec_valid_o=1 and rec_ready_i=0, tag, index and data SHALL remain stable (held by the stall freezing CPU state).
REQ-013 EMIT_PC: tag=0, index=cycle_cnt, data=pc_q; on transfer -> EMIT_REG, idx=0.
REQ-014 EMIT_REG: reg_addr_o=idx, tag=1, index=idx, data=reg_data_i; on transfer idx+1; after idx=NUM_REGS-1 -> EMIT_MEM, idx=0.
REQ-015 EMIT_MEM: mem_addr_o=idx*4, tag=2, index=idx*4, data=mem_data_i; after idx=NUM_MEM_WORDS-1 -> EMIT_END if cycle_cnt==MAX_CYCLES or halt_o=1, else ARMED.
REQ-016 EMIT_END: tag=3, index=cycle_cnt, data=pc_q; on transfer -> DONE.
REQ-017 DONE: done_o=1, stall_o=0; left only by reset; start_i and snap_i ignored.
REQ-018 Halt: per snap, equal-PC counter increments if pc_i==previous snapshot PC, else clears; reaching HALT_LIMIT-1 repeats sets halt_o (sticky).
REQ-019 cycle_cnt SHALL saturate at 16'hFFFF; MAX_CYCLES=0 SHALL mean no cycle limit.
REQ-020 reg_addr_o and mem_addr_o SHALL be 0 outside EMIT_REG/EMIT_MEM.

Reset
REQ-021 rst_i=0 SHALL asynchronously force IDLE; all outputs 0; cycle_cnt, halt, equal-PC counter, idx, pc_q cleared.
REQ-022 Reset mid-snapshot SHALL abort with no further records; stall_o drops immediately.
REQ-023 Deassertion SHALL take effect on the first rising clk_i edge with rst_i=1.

Verification
REQ-024 Reset, start_i=1, one snap_i with pc_i=0x4, ready=1 -> 1+32+8=41 records, PC record first (index 1, data 4), stall_o high exactly 41 cycles, back to ARMED.
REQ-025 Snapshot with rec_ready_i toggling 1/0 -> every record held while ready=0, no record dropped or repeated, register order 0..31, mem addresses 0x00..0x1C.
REQ-026 MAX_CYCLES=3, snaps with PCs 0,4,8 -> after third snapshot, END record index 3 data 8, done_o=1, later snap_i ignored.
REQ-027 Snaps with PC 0x10 four times -> halt_o=1 after fourth, END after that snapshot's MEM records.
REQ-028 rst_i=0 during EMIT_REG idx=10 -> rec_valid_o and stall_o 0 asynchronously; after release state IDLE, cycle_cnt_o=0.
REQ-029 snap_i in IDLE and while stall_o=1 -> ignored, cycle_cnt unchanged.
